vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator and pixel output stage; the next generation of the team's fixed 640x480 VGA controller. It generates programmable horizontal and vertical timing, a pixel-clock enable, and prefetch coordinates for a pixel source of known latency. Sync, data-enable and RGB outputs are realigned to the returned pixel data. It sits between the game/frame logic (the pixel source) and the VGA connector pins.

---
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA raster timing with a prefetch coordinate
// port for a pixel source of known latency. Sync, data-enable, colour and
// frame/line markers are delayed to line up with the returned pixel data.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   RGB_W    = 3,
  parameter int   LAT      = 0,
  parameter int   CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] fetch_x,
  output logic [CNT_W-1:0] fetch_y,
  input  logic [RGB_W-1:0] pix_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Refuse to build counters too narrow for the raster or an unsupported latency.
  if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_cnt_w_bad
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if ((LAT < 0) || (LAT > 7)) begin : g_lat_bad
    $error("vga_timing_gen: LAT must be in 0..7");
  end

  // Raw timing flags for one counter position, all active-high.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } tim_t;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  tim_t             tim_raw;
  tim_t             tim_d;

  assign fetch_x = h_cnt;
  assign fetch_y = v_cnt;

  // Raster counters: h wraps at the end of the line, v steps on each h wrap.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Decode sync windows, visible area and line/frame origin from the counters.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    tim_raw    = '0;
    tim_raw.hs = (32'(h_cnt) >= HS_BEG) && (32'(h_cnt) < HS_END);
    tim_raw.vs = (32'(v_cnt) >= VS_BEG) && (32'(v_cnt) < VS_END);
    tim_raw.de = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    tim_raw.ls = (h_cnt == '0);
    tim_raw.fs = (h_cnt == '0) && (v_cnt == '0);
  end

  if (LAT == 0) begin : g_bypass
    assign tim_d = tim_raw;
  end else begin : g_delay
    tim_t dly_q [LAT];

    // Shift the timing flags LAT enabled cycles to match the pixel source.
    // NOTE: this small array is reset because it carries control flags; a
    // stale de/ls/fs after reset would emit a bogus pixel or marker.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
      end else if (en) begin
        dly_q[0] <= tim_raw;
        for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign tim_d = dly_q[LAT-1];
  end

  // Output stage: levels load on enabled edges, markers last exactly one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      rgb         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= en & tim_d.ls;
      frame_start <= en & tim_d.fs;
      if (en) begin
        hsync <= tim_d.hs ? H_POL : ~H_POL;
        vsync <= tim_d.vs ? V_POL : ~V_POL;
        de    <= tim_d.de;
        rgb   <= tim_d.de ? pix_rgb : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations (default 640x480 LAT=0,
// tiny raster with positive syncs, small raster with LAT=3) driven with a
// common clock/enable and compared every cycle against a position-based model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int hpol, vpol, lat;
  } cfg_t;

  localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0};
  localparam cfg_t CFG_B = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 0};
  localparam cfg_t CFG_C = '{16, 3, 4, 5, 6, 2, 3, 2, 0, 0, 3};

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic [9:0] fx_a, fy_a;
  logic [3:0] fx_b, fy_b;
  logic [4:0] fx_c, fy_c;
  logic [2:0] pix_a, pix_b, pix_c, rgb_a, rgb_b, rgb_c;
  logic hs_a, vs_a, de_a, ls_a, fs_a;
  logic hs_b, vs_b, de_b, ls_b, fs_b;
  logic hs_c, vs_c, de_c, ls_c, fs_c;

  int total = 0;
  int bad   = 0;
  int n_a, n_b, n_c;
  int seed;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .en(en), .fetch_x(fx_a), .fetch_y(fy_a), .pix_rgb(pix_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .RGB_W(3), .LAT(0), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .fetch_x(fx_b), .fetch_y(fy_b), .pix_rgb(pix_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0), .RGB_W(3), .LAT(3), .CNT_W(5)
  ) u_c (
    .clk(clk), .rst(rst), .en(en), .fetch_x(fx_c), .fetch_y(fy_c), .pix_rgb(pix_c),
    .hsync(hs_c), .vsync(vs_c), .de(de_c), .rgb(rgb_c),
    .line_start(ls_c), .frame_start(fs_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Pixel colour the source returns for a raster position.
  function automatic int color(input int pos);
    return ((pos * 37) ^ (pos >> 4) ^ seed) & 7;
  endfunction

  function automatic int frame_len(input cfg_t c);
    return (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
  endfunction

  // Pixel source: after n enabled edges, return the colour fetched LAT cycles ago.
  function automatic logic [2:0] pix_for(input cfg_t c, input int n);
    if (n >= c.lat) return 3'(color((n - c.lat) % frame_len(c)));
    return 3'($urandom);
  endfunction

  // Model: after n enabled edges the counters sit at position n mod frame and
  // the outputs show position n-LAT-1 (inactive before that).
  task automatic check_dut(input string nm, input cfg_t c, input int n, input bit en_edge,
                           input logic [31:0] fx, input logic [31:0] fy,
                           input logic hs, input logic vs, input logic de,
                           input logic [31:0] rgb, input logic ls, input logic fs);
    int ht, fr, p, q, qh, qv;
    int e_hs, e_vs, e_de, e_rgb, e_ls, e_fs;
    ht = c.ha + c.hf + c.hs + c.hb;
    fr = frame_len(c);
    p  = n % fr;
    e_hs = !c.hpol; e_vs = !c.vpol; e_de = 0; e_rgb = 0; e_ls = 0; e_fs = 0;
    if (n >= c.lat + 1) begin
      q  = (n - c.lat - 1) % fr;
      qh = q % ht;
      qv = q / ht;
      if (qh >= c.ha + c.hf && qh < c.ha + c.hf + c.hs) e_hs = c.hpol;
      if (qv >= c.va + c.vf && qv < c.va + c.vf + c.vs) e_vs = c.vpol;
      e_de  = (qh < c.ha && qv < c.va) ? 1 : 0;
      e_rgb = e_de ? color(q) : 0;
      e_ls  = (en_edge && qh == 0) ? 1 : 0;
      e_fs  = (en_edge && q == 0) ? 1 : 0;
    end
    check({nm, ".fetch_x"}, fx, p % ht);
    check({nm, ".fetch_y"}, fy, p / ht);
    check({nm, ".hsync"}, 32'(hs), e_hs);
    check({nm, ".vsync"}, 32'(vs), e_vs);
    check({nm, ".de"}, 32'(de), e_de);
    check({nm, ".rgb"}, rgb, e_rgb);
    check({nm, ".line_start"}, 32'(ls), e_ls);
    check({nm, ".frame_start"}, 32'(fs), e_fs);
  endtask

  task automatic check_all(input bit en_edge);
    check_dut("A", CFG_A, n_a, en_edge, 32'(fx_a), 32'(fy_a), hs_a, vs_a, de_a, 32'(rgb_a), ls_a, fs_a);
    check_dut("B", CFG_B, n_b, en_edge, 32'(fx_b), 32'(fy_b), hs_b, vs_b, de_b, 32'(rgb_b), ls_b, fs_b);
    check_dut("C", CFG_C, n_c, en_edge, 32'(fx_c), 32'(fy_c), hs_c, vs_c, de_c, 32'(rgb_c), ls_c, fs_c);
  endtask

  // One clk: drive en and pixels, advance the model on enabled edges, check at negedge.
  task automatic step(input bit new_en);
    bit edge_en;
    en    = new_en;
    pix_a = pix_for(CFG_A, n_a);
    pix_b = pix_for(CFG_B, n_b);
    pix_c = pix_for(CFG_C, n_c);
    @(posedge clk);
    edge_en = en && !rst;
    if (edge_en) begin
      n_a++; n_b++; n_c++;
    end
    @(negedge clk);
    check_all(edge_en);
  endtask

  initial begin
    seed = int'($urandom & 32'h7);
    n_a = 0; n_b = 0; n_c = 0;
    rst = 1'b1; en = 1'b0;
    pix_a = '0; pix_b = '0; pix_c = '0;
    repeat (2) @(negedge clk);
    check_all(1'b0);
    rst = 1'b0;

    // Free-running pixel clock.
    repeat (3000) step(1'b1);
    // Half-rate enable: 1,0,1,0.
    for (int i = 0; i < 3400; i++) step(i % 2 == 0);
    // Random enable duty.
    repeat (3000) step($urandom_range(0, 3) != 0);

    // Asynchronous reset mid-line: outputs must clear before the next edge.
    repeat ($urandom_range(100, 900)) step(1'b1);
    rst = 1'b1;
    #1;
    n_a = 0; n_b = 0; n_c = 0;
    check_all(1'b0);
    repeat (2) step(1'b1);
    rst = 1'b0;

    // Restart from (0,0) with en high, then a random tail.
    repeat (1500) step(1'b1);
    repeat (800) step($urandom_range(0, 1) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
